// File: rtl/vit_punct.sv
// rtl/vit_punct.sv - Viterbi encoder puncturer and LSB-first output word packer
module vit_punct #(
    parameter int pCODE_GEN_NUM = 2,
    parameter int pPUNCT_PERIOD = 3,
    parameter logic [pCODE_GEN_NUM*pPUNCT_PERIOD-1:0] pPUNCT_PATTERN = 6'b100111,
    parameter int pOUT_W        = 8,
    parameter int pTAG_W        = 4
) (
    input  logic                     iclk,
    input  logic                     iresetn,
    input  logic                     iclkena,
    input  logic                     isop,
    input  logic                     ival,
    input  logic                     ieop,
    input  logic [pTAG_W-1:0]        itag,
    input  logic [pCODE_GEN_NUM-1:0] idat,
    output logic                     osop,
    output logic                     oval,
    output logic                     oeop,
    output logic [pTAG_W-1:0]        otag,
    output logic [pOUT_W-1:0]        odat
);

    localparam int G  = pCODE_GEN_NUM;
    localparam int W  = pOUT_W;
    localparam int AW = W + G - 1;
    localparam int XW = W + 2 * G;
    localparam int CW = $clog2(W + G + 1);
    localparam int PW = (pPUNCT_PERIOD > 1) ? $clog2(pPUNCT_PERIOD) : 1;

    logic [PW-1:0]     ph, phase, ph_nxt, ph_d;
    logic [CW-1:0]     cnt, base, total, k, cnt_d;
    logic [AW-1:0]     acc, acc_in, acc_d;
    logic [G-1:0]      keep, kept;
    logic [XW-1:0]     wide, rem;
    logic [W-1:0]      tail, emit_w;
    logic [pTAG_W-1:0] tag_q, tail_tag, tag_eff;
    logic              tail_pend, tail_sop, first_word;
    logic              emit, emit_eop, go_tail, sop_eff;

    always_comb begin
        phase   = isop ? '0 : ph;
        base    = isop ? '0 : cnt;
        acc_in  = isop ? '0 : acc;
        sop_eff = isop | first_word;
        tag_eff = isop ? itag : tag_q;
        ph_nxt  = (phase == PW'(pPUNCT_PERIOD - 1)) ? '0 : phase + PW'(1);
        keep    = pPUNCT_PATTERN[int'(phase)*G +: G];

        // Compact the kept generator bits, lowest generator first
        kept = '0;
        k    = '0;
        for (int g = 0; g < G; g++) begin
            if (keep[g]) begin
                kept = kept | (G'(idat[g]) << k);
                k    = k + CW'(1);
            end
        end

        wide  = XW'(acc_in) | (XW'(kept) << base);
        rem   = wide >> W;
        total = base + k;

        emit     = 1'b0;
        emit_eop = 1'b0;
        go_tail  = 1'b0;
        emit_w   = wide[W-1:0];
        acc_d    = acc;
        cnt_d    = cnt;
        ph_d     = ph;
        if (ival) begin
            ph_d = ph_nxt;
            if (ieop) begin
                acc_d = '0;
                cnt_d = '0;
                if (total > CW'(W)) begin
                    emit    = 1'b1;
                    go_tail = 1'b1;
                    ph_d    = '0;
                end else if (total != '0) begin
                    emit     = 1'b1;
                    emit_eop = 1'b1;
                end
            end else if (total >= CW'(W)) begin
                emit  = 1'b1;
                acc_d = AW'(rem);
                cnt_d = total - CW'(W);
            end else begin
                acc_d = AW'(wide);
                cnt_d = total;
            end
        end
    end

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            ph         <= '0;
            cnt        <= '0;
            acc        <= '0;
            tail       <= '0;
            tail_pend  <= 1'b0;
            tail_sop   <= 1'b0;
            tail_tag   <= '0;
            first_word <= 1'b0;
            tag_q      <= '0;
            oval       <= 1'b0;
            osop       <= 1'b0;
            oeop       <= 1'b0;
            otag       <= '0;
            odat       <= '0;
        end else if (iclkena) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            ph   <= ph_d;
            cnt  <= cnt_d;
            acc  <= acc_d;
            if (ival && isop)
                tag_q <= itag;
            if (ival)
                first_word <= sop_eff & ~emit;
            if (tail_pend) begin
                oval <= 1'b1;
                oeop <= 1'b1;
                osop <= tail_sop;
                odat <= tail;
                otag <= tail_tag;
                // A one-word frame ending in the tail cycle is parked for the next cycle
                if (emit) begin
                    tail     <= emit_w;
                    tail_sop <= sop_eff;
                    tail_tag <= tag_eff;
                end else begin
                    tail_pend <= 1'b0;
                end
            end else if (emit) begin
                oval <= 1'b1;
                osop <= sop_eff;
                oeop <= emit_eop;
                odat <= emit_w;
                otag <= tag_eff;
                if (go_tail) begin
                    tail      <= W'(rem);
                    tail_pend <= 1'b1;
                    tail_sop  <= 1'b0;
                    tail_tag  <= tag_eff;
                end
            end else if (ival && isop) begin
                otag <= itag;
            end
        end
    end

endmodule

// File: tb/tb_vit_punct.sv
// tb/tb_vit_punct.sv - directed self-checking bench for vit_punct
module tb_vit_punct;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [3:0]  tag;
        logic [7:0]  dat;
        logic [31:0] cyc;
    } word_t;

    logic       iclk = 1'b0;
    logic       iresetn, iclkena, isop, ival, ieop;
    logic [3:0] itag;
    logic [1:0] idat;

    logic       a_sop, a_val, a_eop;
    logic [3:0] a_tag;
    logic [7:0] a_dat;
    logic       b_sop, b_val, b_eop;
    logic [3:0] b_tag;
    logic [2:0] b_dat;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_cyc;
    logic        en_prev = 1'b0;
    word_t       qa[$];
    word_t       qb[$];

    vit_punct da (
        .iclk(iclk), .iresetn(iresetn), .iclkena(iclkena),
        .isop(isop), .ival(ival), .ieop(ieop), .itag(itag), .idat(idat),
        .osop(a_sop), .oval(a_val), .oeop(a_eop), .otag(a_tag), .odat(a_dat)
    );

    vit_punct #(
        .pCODE_GEN_NUM(2), .pPUNCT_PERIOD(1), .pPUNCT_PATTERN(2'b11),
        .pOUT_W(3), .pTAG_W(4)
    ) db (
        .iclk(iclk), .iresetn(iresetn), .iclkena(iclkena),
        .isop(isop), .ival(ival), .ieop(ieop), .itag(itag), .idat(idat),
        .osop(b_sop), .oval(b_val), .oeop(b_eop), .otag(b_tag), .odat(b_dat)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) begin
        en_prev <= iclkena;
        cyc     <= cyc + 1;
    end

    // A word is new only if the edge that registered it was enabled
    always @(negedge iclk) begin
        if (en_prev && a_val) qa.push_back({a_sop, a_eop, a_tag, a_dat, cyc});
        if (en_prev && b_val) qb.push_back({b_sop, b_eop, b_tag, {5'b0, b_dat}, cyc});
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iclk);
            #1;
        end
    endtask

    task automatic sym(input logic s, input logic e, input logic [3:0] t, input logic [1:0] d);
        isop = s; ival = 1'b1; ieop = e; itag = t; idat = d;
        @(negedge iclk);
        #1;
        last_cyc = cyc;
        isop = 1'b0; ival = 1'b0; ieop = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({a_val, a_sop, a_eop, a_tag, a_dat} !== 15'h0) begin
            errors++;
            $display("FAIL reset_a got %h want 0", {a_val, a_sop, a_eop, a_tag, a_dat});
        end
        checks++;
        if ({b_val, b_sop, b_eop, b_tag, b_dat} !== 10'h0) begin
            errors++;
            $display("FAIL reset_b got %h want 0", {b_val, b_sop, b_eop, b_tag, b_dat});
        end
        iresetn = 1'b1;
        idle(2);
    endtask

    task automatic test_full_word();
        word_t w;
        logic [31:0] e;
        qa.delete();
        sym(1, 0, 4'hA, 2'b11);
        for (int i = 0; i < 4; i++) sym(0, 0, 4'h0, 2'b11);
        sym(0, 1, 4'h0, 2'b11);
        e = last_cyc;
        idle(4);
        w = (qa.size() > 0) ? qa[0] : '0;
        checks++;
        if (qa.size() != 1) begin errors++; $display("FAIL full_count got %0d want 1", qa.size()); end
        checks++;
        if ({w.sop, w.eop, w.tag, w.dat} !== {1'b1, 1'b1, 4'hA, 8'hFF}) begin
            errors++;
            $display("FAIL full_word got sop=%b eop=%b tag=%h dat=%h want 1 1 a ff", w.sop, w.eop, w.tag, w.dat);
        end
        checks++;
        if (w.cyc !== e) begin errors++; $display("FAIL full_latency got %0d want %0d", w.cyc, e); end
    endtask

    task automatic test_partial_word();
        word_t w;
        qa.delete();
        sym(1, 0, 4'h2, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 1, 4'h0, 2'b11);
        idle(4);
        w = (qa.size() > 0) ? qa[0] : '0;
        checks++;
        if (qa.size() != 1) begin errors++; $display("FAIL partial_count got %0d want 1", qa.size()); end
        checks++;
        if ({w.sop, w.eop, w.tag, w.dat} !== {1'b1, 1'b1, 4'h2, 8'h3F}) begin
            errors++;
            $display("FAIL partial_word got sop=%b eop=%b tag=%h dat=%h want 1 1 2 3f", w.sop, w.eop, w.tag, w.dat);
        end
    endtask

    task automatic test_bit_order();
        word_t w;
        qa.delete();
        sym(1, 0, 4'h1, 2'b01);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 1, 4'h0, 2'b10);
        idle(4);
        w = (qa.size() > 0) ? qa[0] : '0;
        checks++;
        if ({qa.size() == 1, w.sop, w.eop, w.tag, w.dat} !== {1'b1, 1'b1, 1'b1, 4'h1, 8'h0D}) begin
            errors++;
            $display("FAIL bit_order got n=%0d sop=%b eop=%b tag=%h dat=%h want 1 1 1 1 0d", qa.size(), w.sop, w.eop, w.tag, w.dat);
        end
    endtask

    task automatic test_tail_flush();
        word_t       exp_w[4];
        logic [31:0] e1, e2;
        qb.delete();
        sym(1, 0, 4'h5, 2'b11);
        sym(0, 1, 4'h0, 2'b11);
        e1 = last_cyc;
        sym(1, 0, 4'h9, 2'b11);
        sym(0, 1, 4'h0, 2'b11);
        e2 = last_cyc;
        idle(4);
        exp_w[0] = {1'b1, 1'b0, 4'h5, 8'h07, e1};
        exp_w[1] = {1'b0, 1'b1, 4'h5, 8'h01, e1 + 32'd1};
        exp_w[2] = {1'b1, 1'b0, 4'h9, 8'h07, e2};
        exp_w[3] = {1'b0, 1'b1, 4'h9, 8'h01, e2 + 32'd1};
        checks++;
        if (qb.size() != 4) begin errors++; $display("FAIL tail_count got %0d want 4", qb.size()); end
        for (int i = 0; i < 4; i++) begin
            word_t w;
            w = (qb.size() > i) ? qb[i] : '0;
            checks++;
            if (w !== exp_w[i]) begin
                errors++;
                $display("FAIL tail_word%0d got sop=%b eop=%b tag=%h dat=%h cyc=%0d want sop=%b eop=%b tag=%h dat=%h cyc=%0d",
                         i, w.sop, w.eop, w.tag, w.dat, w.cyc,
                         exp_w[i].sop, exp_w[i].eop, exp_w[i].tag, exp_w[i].dat, exp_w[i].cyc);
            end
        end
    endtask

    task automatic test_abort();
        word_t w;
        qa.delete();
        sym(1, 0, 4'h3, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        idle(3);
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL abort_quiet got %0d words want 0", qa.size()); end
        sym(1, 0, 4'h4, 2'b01);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 1, 4'h0, 2'b10);
        idle(4);
        w = (qa.size() > 0) ? qa[0] : '0;
        checks++;
        if ({qa.size() == 1, w.sop, w.eop, w.tag, w.dat} !== {1'b1, 1'b1, 1'b1, 4'h4, 8'h0D}) begin
            errors++;
            $display("FAIL abort_restart got n=%0d sop=%b eop=%b tag=%h dat=%h want 1 1 1 4 0d", qa.size(), w.sop, w.eop, w.tag, w.dat);
        end
    endtask

    task automatic test_reset_mid_frame();
        word_t w;
        qa.delete();
        sym(1, 0, 4'h6, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        sym(0, 0, 4'h0, 2'b11);
        iresetn = 1'b0;
        #2;
        checks++;
        if ({a_val, a_sop, a_eop, a_tag, a_dat} !== 15'h0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", {a_val, a_sop, a_eop, a_tag, a_dat});
        end
        idle(2);
        iresetn = 1'b1;
        idle(2);
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL midreset_quiet got %0d words want 0", qa.size()); end
        sym(0, 1, 4'hF, 2'b01);
        idle(3);
        w = (qa.size() > 0) ? qa[0] : '0;
        checks++;
        if ({qa.size() == 1, w.sop, w.eop, w.tag, w.dat} !== {1'b1, 1'b0, 1'b1, 4'h0, 8'h01}) begin
            errors++;
            $display("FAIL nosop_word got n=%0d sop=%b eop=%b tag=%h dat=%h want 1 0 1 0 01", qa.size(), w.sop, w.eop, w.tag, w.dat);
        end
    endtask

    task automatic test_clkena_tail();
        word_t       w0, w1;
        logic [31:0] e;
        qb.delete();
        sym(1, 0, 4'h7, 2'b11);
        sym(0, 1, 4'h0, 2'b11);
        e = last_cyc;
        iclkena = 1'b0;
        idle(5);
        iclkena = 1'b1;
        idle(4);
        w0 = (qb.size() > 0) ? qb[0] : '0;
        w1 = (qb.size() > 1) ? qb[1] : '0;
        checks++;
        if (qb.size() != 2) begin errors++; $display("FAIL clkena_count got %0d want 2", qb.size()); end
        checks++;
        if (w0 !== {1'b1, 1'b0, 4'h7, 8'h07, e}) begin
            errors++;
            $display("FAIL clkena_word0 got sop=%b eop=%b tag=%h dat=%h cyc=%0d want 1 0 7 07 %0d", w0.sop, w0.eop, w0.tag, w0.dat, w0.cyc, e);
        end
        checks++;
        if (w1 !== {1'b0, 1'b1, 4'h7, 8'h01, e + 32'd6}) begin
            errors++;
            $display("FAIL clkena_tail got sop=%b eop=%b tag=%h dat=%h cyc=%0d want 0 1 7 01 %0d", w1.sop, w1.eop, w1.tag, w1.dat, w1.cyc, e + 32'd6);
        end
    endtask

    initial begin
        iresetn = 1'b0; iclkena = 1'b1;
        isop = 1'b0; ival = 1'b0; ieop = 1'b0; itag = 4'h0; idat = 2'b00;
        test_reset();
        test_full_word();
        test_partial_word();
        test_bit_order();
        test_tail_flush();
        test_abort();
        test_reset_mid_frame();
        test_clkena_tail();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
